// File: rtl/diff_freq_serial_bank_if.sv
// ---------------------------------------------------------------------------
// diff_freq_serial_bank_if
//   Configuration write port of diff_freq_serial_bank. It is driven by the
//   UART command decoder (master) and consumed by the pattern bank (slave).
//   A write takes effect in the cycle the strobe is high and is always
//   accepted.
//
//   cfg_we    1            write strobe, one cycle
//   cfg_sel   3            0 DATA, 1 FREQ, 2 CTRL, 3 PERIOD, 4 REPEAT, 5-7 ignored
//   cfg_ch    CH_W         target channel (ignored for PERIOD)
//   cfg_data  DATA_BIT     write payload
// ---------------------------------------------------------------------------
interface diff_freq_serial_bank_if #(
  parameter int CH_NUM   = 16,
  parameter int DATA_BIT = 32
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic                cfg_we;
  logic [2:0]          cfg_sel;
  logic [CH_W-1:0]     cfg_ch;
  logic [DATA_BIT-1:0] cfg_data;

  modport master (output cfg_we, cfg_sel, cfg_ch, cfg_data);
  modport slave  (input  cfg_we, cfg_sel, cfg_ch, cfg_data);
endinterface

// File: rtl/diff_freq_serial_bank.sv
// ---------------------------------------------------------------------------
// diff_freq_serial_bank
//   Multi-channel serial pattern generator. Each channel shifts its pattern
//   out LSB first; every bit is held for the SLOW or FAST period, selected
//   per bit by the channel's FREQ mask. One-shot, continuous and N-repeat
//   modes. DATA/FREQ writes land in shadow registers and are copied into the
//   active registers at every frame start.
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous reset, active high
//   cfg           configuration write port (diff_freq_serial_bank_if.slave)
//   stop_i        global stop pulse: all channels return to idle
//   serial_out_o  registered serial outputs, one per channel
//   busy_o        channel is running a frame
//   done_o        (DIFF_FREQ_DONE_PULSE_EN only) one-cycle pulse when a
//                 channel finishes naturally (one-shot, or repeats exhausted)
//
// Build option
//   DIFF_FREQ_DONE_PULSE_EN  defined: adds done_o and its logic.
// ---------------------------------------------------------------------------
module diff_freq_serial_bank #(
  parameter int CH_NUM     = 16,
  parameter int DATA_BIT   = 32,
  parameter int PERIOD_BIT = 8,
  parameter int REPEAT_BIT = 8,
  parameter int DEF_SLOW   = 20,
  parameter int DEF_FAST   = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  diff_freq_serial_bank_if.slave      cfg,
  input  logic                        stop_i,
  output logic [CH_NUM-1:0]           serial_out_o,
  output logic [CH_NUM-1:0]           busy_o
`ifdef DIFF_FREQ_DONE_PULSE_EN
  ,
  output logic [CH_NUM-1:0]           done_o
`endif
);

  localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int IDX_W = $clog2(DATA_BIT);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  typedef enum logic [2:0] {
    SEL_DATA   = 3'd0,
    SEL_FREQ   = 3'd1,
    SEL_CTRL   = 3'd2,
    SEL_PERIOD = 3'd3,
    SEL_REPEAT = 3'd4
  } sel_e;

  localparam logic [1:0] MODE_CONT = 2'b01;
  localparam logic [1:0] MODE_REP  = 2'b10;

  // Per-channel state
  state_e                state_q    [CH_NUM];
  state_e                state_d    [CH_NUM];
  logic [DATA_BIT-1:0]   shd_data_q [CH_NUM];
  logic [DATA_BIT-1:0]   shd_data_d [CH_NUM];
  logic [DATA_BIT-1:0]   shd_freq_q [CH_NUM];
  logic [DATA_BIT-1:0]   shd_freq_d [CH_NUM];
  logic [DATA_BIT-1:0]   act_data_q [CH_NUM];
  logic [DATA_BIT-1:0]   act_data_d [CH_NUM];
  logic [DATA_BIT-1:0]   act_freq_q [CH_NUM];
  logic [DATA_BIT-1:0]   act_freq_d [CH_NUM];
  logic [IDX_W-1:0]      bit_idx_q  [CH_NUM];
  logic [IDX_W-1:0]      bit_idx_d  [CH_NUM];
  logic [IDX_W-1:0]      last_q     [CH_NUM];
  logic [IDX_W-1:0]      last_d     [CH_NUM];
  logic [1:0]            mode_q     [CH_NUM];
  logic [1:0]            mode_d     [CH_NUM];
  logic [REPEAT_BIT-1:0] rep_q      [CH_NUM];
  logic [REPEAT_BIT-1:0] rep_d      [CH_NUM];
  logic [REPEAT_BIT-1:0] rep_cnt_q  [CH_NUM];
  logic [REPEAT_BIT-1:0] rep_cnt_d  [CH_NUM];
  logic [PERIOD_BIT-1:0] cnt_q      [CH_NUM];
  logic [PERIOD_BIT-1:0] cnt_d      [CH_NUM];
  logic [CH_NUM-1:0]     en_q, en_d;
  logic [CH_NUM-1:0]     idle_q, idle_d;
  logic [CH_NUM-1:0]     out_q, out_d;
`ifdef DIFF_FREQ_DONE_PULSE_EN
  logic [CH_NUM-1:0]     done_q, done_d;
`endif

  // Shared bit periods
  logic [PERIOD_BIT-1:0] slow_q, slow_d;
  logic [PERIOD_BIT-1:0] fast_q, fast_d;

  // Bit period minus one, the value the down-counter starts from.
  // A programmed period of 0 behaves as 1.
  function automatic logic [PERIOD_BIT-1:0] len_m1(input logic [PERIOD_BIT-1:0] p);
    return (p == '0) ? '0 : p - PERIOD_BIT'(1);
  endfunction

  always_comb begin
    logic             hit;
    logic             wr_ctrl;
    logic             load;
    logic             finish;
    logic [IDX_W-1:0] nxt;

    // NOTE: every signal driven here gets its hold value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    slow_d = slow_q;
    fast_d = fast_q;
    en_d   = en_q;
    idle_d = idle_q;
    out_d  = out_q;
`ifdef DIFF_FREQ_DONE_PULSE_EN
    done_d = '0;
`endif
    if (cfg.cfg_we && cfg.cfg_sel == SEL_PERIOD) begin
      slow_d = cfg.cfg_data[PERIOD_BIT-1:0];
      fast_d = cfg.cfg_data[2*PERIOD_BIT-1:PERIOD_BIT];
    end

    for (int c = 0; c < CH_NUM; c++) begin
      state_d[c]    = state_q[c];
      shd_data_d[c] = shd_data_q[c];
      shd_freq_d[c] = shd_freq_q[c];
      act_data_d[c] = act_data_q[c];
      act_freq_d[c] = act_freq_q[c];
      bit_idx_d[c]  = bit_idx_q[c];
      last_d[c]     = last_q[c];
      mode_d[c]     = mode_q[c];
      rep_d[c]      = rep_q[c];
      rep_cnt_d[c]  = rep_cnt_q[c];
      cnt_d[c]      = cnt_q[c];
      load          = 1'b0;
      finish        = 1'b0;
      nxt           = '0;

      // Channel numbers >= CH_NUM never match any c and fall through.
      hit     = cfg.cfg_we && (cfg.cfg_ch == CH_W'(c));
      wr_ctrl = hit && (cfg.cfg_sel == SEL_CTRL);

      if (hit && cfg.cfg_sel == SEL_DATA)   shd_data_d[c] = cfg.cfg_data;
      if (hit && cfg.cfg_sel == SEL_FREQ)   shd_freq_d[c] = cfg.cfg_data;
      if (hit && cfg.cfg_sel == SEL_REPEAT) rep_d[c] = cfg.cfg_data[REPEAT_BIT-1:0];
      if (wr_ctrl) begin
        en_d[c]   = cfg.cfg_data[0];
        mode_d[c] = cfg.cfg_data[2:1];
        idle_d[c] = cfg.cfg_data[3];
        last_d[c] = (32'(cfg.cfg_data[15:8]) >= DATA_BIT) ?
                    IDX_W'(DATA_BIT - 1) : IDX_W'(cfg.cfg_data[15:8]);
      end

      // Priority: stop, then CTRL write, then normal frame progress.
      if (stop_i) begin
        state_d[c] = ST_IDLE;
        en_d[c]    = 1'b0;
        out_d[c]   = idle_d[c];
      end else if (wr_ctrl && cfg.cfg_data[0]) begin
        load         = 1'b1;
        rep_cnt_d[c] = rep_q[c];
      end else if (wr_ctrl) begin
        state_d[c] = ST_IDLE;
        out_d[c]   = idle_d[c];
      end else if (state_q[c] == ST_RUN) begin
        if (cnt_q[c] != '0) begin
          cnt_d[c] = cnt_q[c] - PERIOD_BIT'(1);
        end else if (bit_idx_q[c] != last_q[c]) begin
          nxt          = bit_idx_q[c] + IDX_W'(1);
          bit_idx_d[c] = nxt;
          out_d[c]     = act_data_q[c][nxt];
          cnt_d[c]     = len_m1(act_freq_q[c][nxt] ? fast_q : slow_q);
        end else if (mode_q[c] == MODE_CONT) begin
          load = 1'b1;
        end else if (mode_q[c] == MODE_REP && rep_cnt_q[c] != '0) begin
          load         = 1'b1;
          rep_cnt_d[c] = rep_cnt_q[c] - REPEAT_BIT'(1);
        end else begin
          finish = 1'b1;
        end
      end

      // Frame start: latch shadow into active and present bit 0 next cycle.
      if (load) begin
        state_d[c]    = ST_RUN;
        act_data_d[c] = shd_data_q[c];
        act_freq_d[c] = shd_freq_q[c];
        bit_idx_d[c]  = '0;
        out_d[c]      = shd_data_q[c][0];
        cnt_d[c]      = len_m1(shd_freq_q[c][0] ? fast_q : slow_q);
      end

      if (finish) begin
        state_d[c] = ST_IDLE;
        en_d[c]    = 1'b0;
        out_d[c]   = idle_q[c];
`ifdef DIFF_FREQ_DONE_PULSE_EN
        done_d[c]  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: the pattern and config arrays are reset as well as the control
    // state, because their reset contents (zero data, zero repeat) are what a
    // channel sends if it is started without being configured.
    if (rst_i) begin
      for (int c = 0; c < CH_NUM; c++) begin
        state_q[c]    <= ST_IDLE;
        shd_data_q[c] <= '0;
        shd_freq_q[c] <= '0;
        act_data_q[c] <= '0;
        act_freq_q[c] <= '0;
        bit_idx_q[c]  <= '0;
        last_q[c]     <= '0;
        mode_q[c]     <= '0;
        rep_q[c]      <= '0;
        rep_cnt_q[c]  <= '0;
        cnt_q[c]      <= '0;
      end
      en_q   <= '0;
      idle_q <= '0;
      out_q  <= '0;
      slow_q <= PERIOD_BIT'(DEF_SLOW);
      fast_q <= PERIOD_BIT'(DEF_FAST);
`ifdef DIFF_FREQ_DONE_PULSE_EN
      done_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed from the previous cycle, independent of statement order.
      state_q    <= state_d;
      shd_data_q <= shd_data_d;
      shd_freq_q <= shd_freq_d;
      act_data_q <= act_data_d;
      act_freq_q <= act_freq_d;
      bit_idx_q  <= bit_idx_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      rep_q      <= rep_d;
      rep_cnt_q  <= rep_cnt_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      idle_q     <= idle_d;
      out_q      <= out_d;
      slow_q     <= slow_d;
      fast_q     <= fast_d;
`ifdef DIFF_FREQ_DONE_PULSE_EN
      done_q     <= done_d;
`endif
    end
  end

  assign serial_out_o = out_q;
`ifdef DIFF_FREQ_DONE_PULSE_EN
  assign done_o = done_q;
`endif

  always_comb begin
    busy_o = '0;
    for (int c = 0; c < CH_NUM; c++) busy_o[c] = (state_q[c] == ST_RUN);
  end

endmodule

// File: tb/tb_diff_freq_serial_bank.sv
// ---------------------------------------------------------------------------
// tb_diff_freq_serial_bank
//   Directed bench for diff_freq_serial_bank with 6 channels (so channel
//   numbers 6 and 7 exist on the bus but not in the design). A vector table
//   covers reset, ignored writes, stop-versus-start and the zero-period
//   frame; hand-written sequences cover bit timing, mixed periods, repeat,
//   continuous reload, restart, disable and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_diff_freq_serial_bank;

  localparam int CH = 6;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stop_i;
  logic [CH-1:0] serial_out_o;
  logic [CH-1:0] busy_o;
`ifdef DIFF_FREQ_DONE_PULSE_EN
  logic [CH-1:0] done_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  diff_freq_serial_bank_if #(.CH_NUM(CH), .DATA_BIT(32)) cfg_if ();

  diff_freq_serial_bank #(.CH_NUM(CH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg         (cfg_if),
    .stop_i      (stop_i),
    .serial_out_o(serial_out_o),
    .busy_o      (busy_o)
`ifdef DIFF_FREQ_DONE_PULSE_EN
    ,
    .done_o      (done_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          we;
    logic [2:0]    sel;
    logic [2:0]    ch;
    logic [31:0]   data;
    logic          stop;
    logic [CH-1:0] exp_out;
    logic [CH-1:0] exp_busy;
    string         name;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [2:0] sel, input logic [2:0] ch,
                              input logic [31:0] data, input logic stop,
                              input logic [CH-1:0] eo, input logic [CH-1:0] eb,
                              input string name);
    vec_t v;
    v.we = we; v.sel = sel; v.ch = ch; v.data = data; v.stop = stop;
    v.exp_out = eo; v.exp_busy = eb; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a falling edge; drives inputs for one rising edge, then clears
  // them. Returns at the next falling edge, where the result is visible.
  task automatic tick(input logic we, input logic [2:0] sel, input logic [2:0] ch,
                      input logic [31:0] data, input logic stop);
    cfg_if.cfg_we   = we;
    cfg_if.cfg_sel  = sel;
    cfg_if.cfg_ch   = ch;
    cfg_if.cfg_data = data;
    stop_i          = stop;
    @(negedge clk_i);
    cfg_if.cfg_we   = 1'b0;
    cfg_if.cfg_sel  = 3'd0;
    cfg_if.cfg_ch   = 3'd0;
    cfg_if.cfg_data = 32'd0;
    stop_i          = 1'b0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [2:0] ch, input logic [31:0] data);
    tick(1'b1, sel, ch, data, 1'b0);
  endtask

  // Expect {out, busy} of one channel for n consecutive cycles.
  task automatic hold(input string name, input int ch, input logic eo, input logic eb,
                      input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", name, i), 32'({serial_out_o[ch], busy_o[ch]}),
            32'({eo, eb}));
      @(negedge clk_i);
    end
  endtask

  task automatic check_done(input string name, input int ch, input logic exp);
`ifdef DIFF_FREQ_DONE_PULSE_EN
    check(name, 32'(done_o[ch]), 32'(exp));
`endif
  endtask

  initial begin
    rst_i           = 1'b1;
    stop_i          = 1'b0;
    cfg_if.cfg_we   = 1'b0;
    cfg_if.cfg_sel  = 3'd0;
    cfg_if.cfg_ch   = 3'd0;
    cfg_if.cfg_data = 32'd0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // CTRL word: [0] en, [2:1] mode, [3] idle, [15:8] last_bit
    vecs[0]  = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b000000, 6'b000000, "reset_idle");
    vecs[1]  = mk(1, 3'd2, 3'd4, 32'h8,    0, 6'b010000, 6'b000000, "idle_high_ch4");
    vecs[2]  = mk(1, 3'd5, 3'd4, 32'h0,    0, 6'b010000, 6'b000000, "sel5_ignored");
    vecs[3]  = mk(1, 3'd2, 3'd6, 32'h8,    0, 6'b010000, 6'b000000, "ch6_ignored");
    vecs[4]  = mk(1, 3'd0, 3'd5, 32'h1,    0, 6'b010000, 6'b000000, "data_ch5");
    vecs[5]  = mk(1, 3'd2, 3'd5, 32'h9,    1, 6'b110000, 6'b000000, "start_vs_stop");
    vecs[6]  = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b110000, 6'b000000, "stop_stays_idle");
    vecs[7]  = mk(1, 3'd3, 3'd0, 32'h0,    0, 6'b110000, 6'b000000, "period_zero");
    vecs[8]  = mk(1, 3'd0, 3'd0, 32'hA5,   0, 6'b110000, 6'b000000, "data_a5");
    vecs[9]  = mk(1, 3'd2, 3'd0, 32'h701,  0, 6'b110001, 6'b000001, "t6_b0");
    vecs[10] = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b110000, 6'b000001, "t6_b1");
    vecs[11] = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b110001, 6'b000001, "t6_b2");
    vecs[12] = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b110000, 6'b000001, "t6_b3");
    vecs[13] = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b110000, 6'b000001, "t6_b4");
    vecs[14] = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b110001, 6'b000001, "t6_b5");
    vecs[15] = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b110000, 6'b000001, "t6_b6");
    vecs[16] = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b110001, 6'b000001, "t6_b7");
    vecs[17] = mk(0, 3'd0, 3'd0, 32'h0,    0, 6'b110000, 6'b000000, "t6_end");
    vecs[18] = mk(1, 3'd3, 3'd0, 32'h0204, 0, 6'b110000, 6'b000000, "period_4_2");

    for (int i = 0; i < NV; i++) begin
      tick(vecs[i].we, vecs[i].sel, vecs[i].ch, vecs[i].data, vecs[i].stop);
      check({vecs[i].name, "_out"},  32'(serial_out_o), 32'(vecs[i].exp_out));
      check({vecs[i].name, "_busy"}, 32'(busy_o),       32'(vecs[i].exp_busy));
    end

    // T1: SLOW=4, ch0 pattern 1,0,1,0 each 4 clocks, one-shot, idle low.
    wr(3'd0, 3'd0, 32'h5);
    wr(3'd1, 3'd0, 32'h0);
    wr(3'd2, 3'd0, 32'h301);
    hold("t1_b0", 0, 1'b1, 1'b1, 4);
    hold("t1_b1", 0, 1'b0, 1'b1, 4);
    hold("t1_b2", 0, 1'b1, 1'b1, 4);
    hold("t1_b3", 0, 1'b0, 1'b1, 4);
    check_done("t1_done", 0, 1'b1);
    hold("t1_idle", 0, 1'b0, 1'b0, 1);
    check_done("t1_done_once", 0, 1'b0);

    // T2: ch1 bit0 slow (4), bit1 fast (2).
    wr(3'd1, 3'd1, 32'h2);
    wr(3'd0, 3'd1, 32'h3);
    wr(3'd2, 3'd1, 32'h101);
    hold("t2_frame", 1, 1'b1, 1'b1, 6);
    hold("t2_idle",  1, 1'b0, 1'b0, 1);
    // Same timing, pattern 0,1 so the two bit lengths are visible.
    wr(3'd0, 3'd1, 32'h2);
    wr(3'd2, 3'd1, 32'h101);
    hold("t2b_b0",   1, 1'b0, 1'b1, 4);
    hold("t2b_b1",   1, 1'b1, 1'b1, 2);
    hold("t2b_idle", 1, 1'b0, 1'b0, 1);

    // T3: SLOW=3, ch2 repeat mode with REPEAT=2 -> three frames back to back.
    wr(3'd3, 3'd0, 32'h0203);
    wr(3'd4, 3'd2, 32'h2);
    wr(3'd0, 3'd2, 32'h1);
    wr(3'd2, 3'd2, 32'h5);
    hold("t3_high", 2, 1'b1, 1'b1, 9);
    check_done("t3_done", 2, 1'b1);
    hold("t3_idle", 2, 1'b0, 1'b0, 2);

    // T4: ch3 continuous, idle high, pattern 0,1 (3 clocks each).
    wr(3'd0, 3'd3, 32'h2);
    wr(3'd1, 3'd3, 32'h0);
    wr(3'd2, 3'd3, 32'h10B);
    wr(3'd0, 3'd3, 32'h1);              // rewrite during the first frame
    hold("t4_old_b0", 3, 1'b0, 1'b1, 2);
    hold("t4_old_b1", 3, 1'b1, 1'b1, 3);
    hold("t4_new_b0", 3, 1'b1, 1'b1, 3);
    hold("t4_new_b1", 3, 1'b0, 1'b1, 3);
    tick(1'b0, 3'd0, 3'd0, 32'h0, 1'b1);
    check_done("t4_stop_no_done", 3, 1'b0);
    hold("t4_stopped", 3, 1'b1, 1'b0, 2);

    // Restart while running: frame starts over from bit 0.
    wr(3'd0, 3'd4, 32'hF);
    wr(3'd2, 3'd4, 32'h301);
    hold("rs_first", 4, 1'b1, 1'b1, 2);
    wr(3'd2, 3'd4, 32'h301);
    check_done("rs_no_done", 4, 1'b0);
    hold("rs_frame", 4, 1'b1, 1'b1, 12);
    check_done("rs_done", 4, 1'b1);
    hold("rs_idle", 4, 1'b0, 1'b0, 1);

    // Disable while running: idle next cycle, no completion pulse.
    wr(3'd2, 3'd4, 32'h301);
    hold("dis_run", 4, 1'b1, 1'b1, 2);
    wr(3'd2, 3'd4, 32'h0);
    check_done("dis_no_done", 4, 1'b0);
    hold("dis_idle", 4, 1'b0, 1'b0, 2);

    // Reset mid-frame: every output low on the next edge.
    wr(3'd2, 3'd0, 32'h309);
    hold("rst_run", 0, 1'b1, 1'b1, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_mid_out",  32'(serial_out_o), 32'd0);
    check("rst_mid_busy", 32'(busy_o),       32'd0);
    check_done("rst_no_done", 0, 1'b0);
    @(negedge clk_i);
    check("rst_after_out", 32'(serial_out_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
